// File: rtl/dmem_arbiter.sv
`default_nettype none
// dmem_arbiter: round-robin sharing of the byte-lane data SRAM bank between the core
// load/store path and the loader, with fixed SETUP/STROBE/HOLD sequencing.
module dmem_arbiter #(
  parameter int WAIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req,
  input  logic [7:0]  core_op,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  output logic        core_ack,
  output logic        core_err,
  input  logic        ldr_req,
  input  logic        ldr_we,
  input  logic [31:0] ldr_addr,
  input  logic [31:0] ldr_wdata,
  output logic [31:0] ldr_rdata,
  output logic        ldr_ack,
  output logic [14:0] ram_addr,
  output logic [3:0]  ram_ce_n,
  output logic        ram_oe_n,
  output logic [3:0]  ram_we_n,
  output logic [31:0] ram_wdata,
  output logic        ram_wdata_oe,
  input  logic [31:0] ram_rdata
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, ERR} state_t;

  localparam logic [3:0] LAST = 4'(WAIT - 1);

  state_t      state;
  logic        prio_ldr;
  logic        sel_ldr;
  logic        is_wr;
  logic        is_signed;
  logic [1:0]  size;
  logic [1:0]  off;
  logic [3:0]  lanes;
  logic [3:0]  cnt;

  logic [7:0]  opz;
  logic        c_byte, c_half, c_word, c_wr, c_sgn, c_err;
  logic [3:0]  c_lanes;
  logic [31:0] c_wdata;
  logic [7:0]  rd_b;
  logic [15:0] rd_h;
  logic [31:0] rd_ext;
  logic        grant_core;
  logic        unused_bits;

  assign unused_bits = ^{core_addr[31:17], ldr_addr[31:17], ldr_addr[1:0]};
  assign opz         = ~core_op;
  assign grant_core  = core_req && (!ldr_req || !prio_ldr);

  // Decode of the active-low one-hot op into size, direction and lanes.
  always_comb begin
    c_byte  = opz[7] | opz[4] | opz[2];
    c_half  = opz[6] | opz[3] | opz[1];
    c_word  = opz[5] | opz[0];
    c_wr    = |opz[2:0];
    c_sgn   = opz[7] | opz[6];
    c_err   = ($countones(opz) != 1) || (c_half && core_addr[0]) ||
              (c_word && (core_addr[1:0] != 2'b00));
    c_lanes = 4'b1111;
    c_wdata = core_wdata;
    if (c_byte) begin
      c_lanes = 4'b0001 << core_addr[1:0];
      c_wdata = {4{core_wdata[7:0]}};
    end else if (c_half) begin
      c_lanes = core_addr[1] ? 4'b1100 : 4'b0011;
      c_wdata = {2{core_wdata[15:0]}};
    end
  end

  always_comb begin
    rd_b = ram_rdata[{off, 3'b000} +: 8];
    rd_h = off[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (size)
      2'd0:    rd_ext = is_signed ? {{24{rd_b[7]}}, rd_b} : {24'b0, rd_b};
      2'd1:    rd_ext = is_signed ? {{16{rd_h[15]}}, rd_h} : {16'b0, rd_h};
      default: rd_ext = ram_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      prio_ldr     <= 1'b0;
      sel_ldr      <= 1'b0;
      is_wr        <= 1'b0;
      is_signed    <= 1'b0;
      size         <= 2'd0;
      off          <= 2'd0;
      lanes        <= 4'h0;
      cnt          <= 4'h0;
      ram_addr     <= 15'h0;
      ram_ce_n     <= 4'hF;
      ram_oe_n     <= 1'b1;
      ram_we_n     <= 4'hF;
      ram_wdata    <= 32'h0;
      ram_wdata_oe <= 1'b0;
      core_ack     <= 1'b0;
      core_err     <= 1'b0;
      ldr_ack      <= 1'b0;
      core_rdata   <= 32'h0;
      ldr_rdata    <= 32'h0;
    end else begin
      core_ack <= 1'b0;
      core_err <= 1'b0;
      ldr_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_core) begin
            sel_ldr  <= 1'b0;
            prio_ldr <= 1'b1;
            if (c_err) begin
              state    <= ERR;
              core_ack <= 1'b1;
              core_err <= 1'b1;
            end else begin
              state        <= SETUP;
              is_wr        <= c_wr;
              is_signed    <= c_sgn;
              size         <= c_byte ? 2'd0 : (c_half ? 2'd1 : 2'd2);
              off          <= core_addr[1:0];
              lanes        <= c_lanes;
              ram_addr     <= core_addr[16:2];
              ram_wdata    <= c_wdata;
              ram_ce_n     <= ~c_lanes;
              ram_wdata_oe <= c_wr;
            end
          end else if (ldr_req) begin
            sel_ldr      <= 1'b1;
            prio_ldr     <= 1'b0;
            state        <= SETUP;
            is_wr        <= ldr_we;
            is_signed    <= 1'b0;
            size         <= 2'd2;
            off          <= 2'd0;
            lanes        <= 4'hF;
            ram_addr     <= ldr_addr[16:2];
            ram_wdata    <= ldr_wdata;
            ram_ce_n     <= 4'h0;
            ram_wdata_oe <= ldr_we;
          end
        end
        SETUP: begin
          state <= STROBE;
          cnt   <= 4'h0;
          if (is_wr) ram_we_n <= ~lanes;
          else       ram_oe_n <= 1'b0;
        end
        STROBE: begin
          // Read data is captured on the edge that ends the final strobe cycle.
          if (cnt == LAST) begin
            state    <= HOLD;
            ram_oe_n <= 1'b1;
            ram_we_n <= 4'hF;
            if (sel_ldr) begin
              ldr_ack <= 1'b1;
              if (!is_wr) ldr_rdata <= ram_rdata;
            end else begin
              core_ack <= 1'b1;
              if (!is_wr) core_rdata <= rd_ext;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        HOLD: begin
          state        <= IDLE;
          ram_ce_n     <= 4'hF;
          ram_wdata_oe <= 1'b0;
        end
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// tb_dmem_arbiter: directed and randomized checks of dmem_arbiter against a
// transaction-level model holding a byte-addressed memory image.
module tb_dmem_arbiter;
  localparam int W = 2;
  localparam logic [7:0] LB = 8'h7F, LH = 8'hBF, LW = 8'hDF, LBU = 8'hEF;
  localparam logic [7:0] SB = 8'hFB, SH = 8'hFD, SW = 8'hFE;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        core_req = 1'b0;
  logic [7:0]  core_op = 8'hFF;
  logic [31:0] core_addr = 32'h0, core_wdata = 32'h0;
  logic [31:0] core_rdata;
  logic        core_ack, core_err;
  logic        ldr_req = 1'b0, ldr_we = 1'b0;
  logic [31:0] ldr_addr = 32'h0, ldr_wdata = 32'h0;
  logic [31:0] ldr_rdata;
  logic        ldr_ack;
  logic [14:0] ram_addr;
  logic [3:0]  ram_ce_n, ram_we_n;
  logic        ram_oe_n, ram_wdata_oe;
  logic [31:0] ram_wdata, ram_rdata;

  dmem_arbiter #(.WAIT(W)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_op(core_op), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_ack(core_ack), .core_err(core_err),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_rdata(ldr_rdata), .ldr_ack(ldr_ack),
    .ram_addr(ram_addr), .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n),
    .ram_wdata(ram_wdata), .ram_wdata_oe(ram_wdata_oe), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // SRAM bank: byte lanes written while ce/we are low, data driven only while oe is low.
  logic [31:0] sram [0:32767];
  logic [31:0] junk;
  always @(posedge clk) begin
    junk <= $urandom;
    for (int i = 0; i < 4; i++)
      if (!ram_we_n[i] && !ram_ce_n[i]) sram[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
  end
  assign ram_rdata = ram_oe_n ? junk : sram[ram_addr];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: cycle %0d got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: one transaction record per grant, memory as a byte image.
  logic [7:0]  mimg [0:131071];
  int          g = -1000;
  int          free_at = 0;
  bit          prio_ldr = 1'b0;
  bit          after_rst = 1'b0;
  bit          a_ldr = 1'b0, a_err = 1'b0, a_wr = 1'b0;
  logic [3:0]  a_lanes = 4'h0;
  logic [14:0] a_addr = 15'h0;
  logic [31:0] a_wdata = 32'h0, a_rdata = 32'h0;

  task automatic model_core();
    int zc, idx, sz;
    bit sgn;
    logic [16:0] a;
    logic [31:0] v;
    logic signed [31:0] sv;
    zc = 0; idx = 0;
    for (int i = 0; i < 8; i++) if (!core_op[i]) begin zc++; idx = i; end
    sz  = (idx == 7 || idx == 4 || idx == 2) ? 1 : (idx == 6 || idx == 3 || idx == 1) ? 2 : 4;
    sgn = (idx == 7 || idx == 6);
    a   = core_addr[16:0];
    a_wr  = (idx <= 2);
    a_err = (zc != 1) || ((int'(a) % sz) != 0);
    if (!a_err) begin
      a_lanes = 4'((1 << sz) - 1) << a[1:0];
      a_addr  = a[16:2];
      a_wdata = (sz == 1) ? {4{core_wdata[7:0]}} : (sz == 2) ? {2{core_wdata[15:0]}} : core_wdata;
      if (a_wr) begin
        for (int i = 0; i < sz; i++) mimg[int'(a) + i] = core_wdata[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < sz; i++) v = v | (32'(mimg[int'(a) + i]) << (8 * i));
        if (sgn) begin
          sv = v << (32 - 8 * sz);
          sv = sv >>> (32 - 8 * sz);
          v  = sv;
        end
        a_rdata = v;
      end
    end
  endtask

  task automatic model_ldr();
    int base;
    a_err   = 1'b0;
    a_wr    = ldr_we;
    a_lanes = 4'hF;
    a_addr  = ldr_addr[16:2];
    a_wdata = ldr_wdata;
    base    = int'({ldr_addr[16:2], 2'b00});
    if (a_wr) for (int i = 0; i < 4; i++) mimg[base + i] = ldr_wdata[8*i +: 8];
    else      for (int i = 0; i < 4; i++) a_rdata[8*i +: 8] = mimg[base + i];
  endtask

  always @(posedge clk) begin
    if (rst) begin
      g = -1000; free_at = cyc + 1; prio_ldr = 1'b0; after_rst = 1'b1;
    end else begin
      after_rst = 1'b0;
      if (cyc >= free_at && (core_req || ldr_req)) begin
        a_ldr    = ldr_req && (!core_req || prio_ldr);
        prio_ldr = !a_ldr;
        g        = cyc;
        if (a_ldr) model_ldr(); else model_core();
        free_at  = cyc + (a_err ? 2 : W + 3);
      end
    end
    cyc++;
  end

  always @(negedge clk) begin : cmp
    int k;
    bit act;
    logic [3:0] e_ce, e_we;
    logic e_oe, e_bus, e_cack, e_cerr, e_lack;
    if (cyc > 0) begin
      k = cyc - g;
      e_ce = 4'hF; e_we = 4'hF; e_oe = 1'b1; e_bus = 1'b0;
      e_cack = 1'b0; e_cerr = 1'b0; e_lack = 1'b0;
      act = !a_err && k >= 1 && k <= W + 2;
      if (a_err && k == 1) begin e_cack = 1'b1; e_cerr = 1'b1; end
      if (act) begin
        e_ce  = ~a_lanes;
        e_bus = a_wr;
        if (k >= 2 && k <= W + 1) begin
          if (a_wr) e_we = ~a_lanes; else e_oe = 1'b0;
        end
        if (k == W + 2) begin
          if (a_ldr) e_lack = 1'b1; else e_cack = 1'b1;
        end
      end
      chk("ram_ce_n", ram_ce_n, e_ce);
      chk("ram_we_n", ram_we_n, e_we);
      chk("ram_oe_n", ram_oe_n, e_oe);
      chk("ram_wdata_oe", ram_wdata_oe, e_bus);
      chk("core_ack", core_ack, e_cack);
      chk("core_err", core_err, e_cerr);
      chk("ldr_ack", ldr_ack, e_lack);
      if (act) chk("ram_addr", ram_addr, a_addr);
      if (act && a_wr) chk("ram_wdata", ram_wdata, a_wdata);
      if (act && k == W + 2 && !a_wr)
        chk(a_ldr ? "ldr_rdata" : "core_rdata", a_ldr ? ldr_rdata : core_rdata, a_rdata);
      if (after_rst) begin
        chk("rst_ram_addr", ram_addr, 15'h0);
        chk("rst_ram_wdata", ram_wdata, 32'h0);
        chk("rst_core_rdata", core_rdata, 32'h0);
        chk("rst_ldr_rdata", ldr_rdata, 32'h0);
      end
    end
  end

  // Random requesters: a request is dropped on its ack and new operands are only
  // presented while the request line is low.
  bit rand_en = 1'b0;
  bit stop_new = 1'b0;
  always @(negedge clk) begin
    logic [31:0] t;
    if (rand_en) begin
      if (core_req && core_ack) core_req = 1'b0;
      if (!core_req) begin
        core_op    = ($urandom_range(0, 9) == 0) ? 8'($urandom) : ~(8'h01 << $urandom_range(0, 7));
        t          = $urandom;
        t[16:0]    = 17'h100 + 17'($urandom_range(0, 63));
        core_addr  = t;
        core_wdata = $urandom;
        if (!stop_new && $urandom_range(0, 2) != 0) core_req = 1'b1;
      end
      if (ldr_req && ldr_ack) ldr_req = 1'b0;
      if (!ldr_req) begin
        ldr_we     = 1'($urandom);
        t          = $urandom;
        t[16:0]    = 17'h100 + 17'($urandom_range(0, 63));
        ldr_addr   = t;
        ldr_wdata  = $urandom;
        if (!stop_new && $urandom_range(0, 2) != 0) ldr_req = 1'b1;
      end
    end
  end

  task automatic core_do(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd, output logic err, output int lat,
                         output logic [3:0] we_seen, output logic [14:0] addr_seen,
                         output logic [31:0] wd_seen);
    int t0;
    core_op = op; core_addr = addr; core_wdata = wd; core_req = 1'b1;
    t0 = cyc; lat = -1; we_seen = 4'hF;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      @(negedge clk);
      if (ram_we_n != 4'hF) we_seen = ram_we_n;
      if (core_ack) lat = cyc - t0;
    end
    core_req = 1'b0;
    rd = core_rdata; err = core_err; addr_seen = ram_addr; wd_seen = ram_wdata;
    if (lat < 0) chk("core_ack_timeout", 32'h0, 32'h1);
    @(negedge clk);
  endtask

  task automatic ldr_do(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output int lat, output logic [14:0] addr_seen);
    int t0;
    ldr_we = we; ldr_addr = addr; ldr_wdata = wd; ldr_req = 1'b1;
    t0 = cyc; lat = -1;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      @(negedge clk);
      if (ldr_ack) lat = cyc - t0;
    end
    ldr_req = 1'b0;
    rd = ldr_rdata; addr_seen = ram_addr;
    if (lat < 0) chk("ldr_ack_timeout", 32'h0, 32'h1);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd, wds;
    logic err;
    int lat, n, t0;
    logic [3:0] wes;
    logic [14:0] ads;
    int who [0:3];
    int when [0:3];

    for (int i = 0; i < 32768; i++) sram[i] = 32'h0;
    for (int i = 0; i < 131072; i++) mimg[i] = 8'h0;

    repeat (3) @(negedge clk);
    chk("reset_ce_n", ram_ce_n, 4'hF);
    chk("reset_we_n", ram_we_n, 4'hF);
    chk("reset_oe_n", ram_oe_n, 1'b1);
    rst = 1'b0;

    core_do(SW, 32'h100, 32'h11223344, rd, err, lat, wes, ads, wds);
    chk("sw_latency", lat, W + 2);
    chk("sw_we_n", wes, 4'h0);
    chk("sw_ram_addr", ads, 15'h040);
    core_do(SB, 32'h103, 32'h000000A5, rd, err, lat, wes, ads, wds);
    chk("sb_we_n", wes, 4'h7);
    chk("sb_wdata", wds, 32'hA5A5A5A5);
    core_do(LB, 32'h103, 32'h0, rd, err, lat, wes, ads, wds);
    chk("lb_rdata", rd, 32'hFFFFFFA5);
    core_do(LBU, 32'h103, 32'h0, rd, err, lat, wes, ads, wds);
    chk("lbu_rdata", rd, 32'h000000A5);
    core_do(SH, 32'h102, 32'h00008001, rd, err, lat, wes, ads, wds);
    chk("sh_we_n", wes, 4'h3);
    core_do(LH, 32'h102, 32'h0, rd, err, lat, wes, ads, wds);
    chk("lh_rdata", rd, 32'hFFFF8001);
    core_do(LW, 32'h101, 32'h0, rd, err, lat, wes, ads, wds);
    chk("misalign_err", err, 1'b1);
    chk("misalign_latency", lat, 1);
    chk("misalign_no_we", wes, 4'hF);
    ldr_do(1'b1, 32'h7FFC, 32'hDEADBEEF, rd, lat, ads);
    ldr_do(1'b0, 32'h7FFC, 32'h0, rd, lat, ads);
    chk("ldr_ram_addr", ads, 15'h1FFF);
    chk("ldr_rdata_lit", rd, 32'hDEADBEEF);
    core_do(8'hFC, 32'h100, 32'h0, rd, err, lat, wes, ads, wds);
    chk("illegal_err", err, 1'b1);

    // Both requesters held continuously from reset.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    core_op = LW; core_addr = 32'h100; ldr_we = 1'b0; ldr_addr = 32'h100;
    core_req = 1'b1; ldr_req = 1'b1;
    n = 0;
    for (int i = 0; i < 60 && n < 4; i++) begin
      @(negedge clk);
      if (core_ack || ldr_ack) begin who[n] = ldr_ack ? 1 : 0; when[n] = cyc; n++; end
    end
    core_req = 1'b0; ldr_req = 1'b0;
    chk("alt_count", n, 4);
    for (int i = 0; i < n; i++) begin
      chk("alt_who", who[i], i % 2);
      if (i > 0) chk("alt_gap", when[i] - when[i-1], W + 3);
    end
    @(negedge clk);

    // Reset during the strobe of a core write; the held request is served again.
    core_op = SW; core_addr = 32'h120; core_wdata = 32'hCAFEF00D; core_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_we_n", ram_we_n, 4'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_abort_we_n", ram_we_n, 4'hF);
    chk("rst_abort_ack", core_ack, 1'b0);
    rst = 1'b0;
    t0 = cyc; lat = -1;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      @(negedge clk);
      if (core_ack) lat = cyc - t0;
    end
    core_req = 1'b0;
    chk("rst_reserve_latency", lat, W + 2);
    @(negedge clk);

    rand_en = 1'b1;
    repeat (3000) @(negedge clk);
    stop_new = 1'b1;
    for (int i = 0; i < 40 && (core_req || ldr_req); i++) @(negedge clk);
    chk("drain_idle", {30'h0, core_req, ldr_req}, 32'h0);
    rand_en = 1'b0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
